ex_operand_stage: RTL and testbench
===================================

# ex_operand_stage

ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU. It captures one decoded instruction per handshake, resolves register operands against forwarded results from the MEM and WB stages, and presents the ALU operand pair and operation code for the execute stage. It is a single-entry valid/ready register, with flush support for taken branches and jumps.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1_addr, in_rs2_addr  in  5  source register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_use_pc  in  1  ALU in_0 takes PC instead of rs1
- in_use_imm  in  1  ALU in_1 takes immediate instead of rs2
- in_operation  in  4  ALU operation code, passed through unchanged
- in_rd_addr  in  5  destination register
- flush  in  1  kill held and incoming instruction
- fwd_mem_valid, fwd_mem_rd, fwd_mem_data  in  1/5/XLEN  MEM-stage result
- fwd_wb_valid, fwd_wb_rd, fwd_wb_data  in  1/5/XLEN  WB-stage result
- out_valid  out  1  ALU operands valid
- out_ready  in  1  execute stage consumes
- out_in_0, out_in_1  out  XLEN  ALU operands
- out_operation  out  4  ALU operation code
- out_rd_addr  out  5  destination register
- out_store_data  out  XLEN  resolved rs2 value for stores

## Operation
- Registered fields: valid, pc, rs1/rs2 addr, rs1_val, rs2_val, imm, use_pc, use_imm, operation, rd_addr.
- in_ready = !out_valid || out_ready (combinational; no bubble on back-to-back transfers).
- Load: on in_valid && in_ready && !flush, all fields are captured and valid is set. rs1_val and rs2_val are captured through the forwarding resolve.
- Forwarding resolve, per source: if the address is 0, the value is 0. Otherwise, if fwd_mem_valid and fwd_mem_rd matches, use fwd_mem_data. Otherwise, if fwd_wb_valid and fwd_wb_rd matches, use fwd_wb_data. Otherwise use the register-file data. MEM has priority over WB.
- Hold: while out_valid && !out_ready, rs1_val and rs2_val are re-resolved every cycle against the forwarding ports, using the stored addresses and stored values as fallback. All other fields are frozen.
- Consume without new load: valid is cleared.
- Output muxes (combinational from registers):
  - out_in_0 = use_pc ? pc : rs1_val
  - out_in_1 = use_imm ? imm : rs2_val
  - out_store_data = rs2_val
- flush: valid is cleared next cycle regardless of hold state. A simultaneous in_valid transfer is accepted (in_ready is unchanged) and discarded. flush has priority over load.
- Operand arithmetic: none. All widths are XLEN, with no extension or truncation.

## Timing
- Latency: 1 cycle from an accepted input to out_valid.
- Throughput: 1 instruction/cycle when out_ready is held high.
- Reset: out_valid=0. All registered fields are 0, so out_in_0=0, out_in_1=0, out_operation=4'b0000, out_rd_addr=0 and out_store_data=0. in_ready=1 in the cycle after reset deasserts.
- rst asserted mid-hold drops the held instruction. rst has priority over flush and load.
- Outputs remain stable while out_valid && !out_ready. The only exception is the forwarding refresh of rs1_val and rs2_val, which corrects stale operands.
- Forwarding ports are sampled at the capture edge and at every hold edge; they are not applied combinationally to the outputs.

## Configuration
- FORWARDING_EN defined: forwarding resolve is implemented as described above.
- FORWARDING_EN undefined:
  - rs1_val and rs2_val take the register-file data directly.
  - The rs1 = 0 and rs2 = 0 zeroing is still applied.
  - No hold-time refresh takes place.
  - Forwarding inputs are ignored.
  - Hazards must be resolved by upstream stalling.

## Test plan
- Reset, then in_valid with rs1=5 (data 0x10), rs2=6 (data 0x20), use_imm=0, operation=4'h1 -> next cycle: out_valid=1, out_in_0=0x10, out_in_1=0x20, out_operation=4'h1.
- fwd_mem (rd=5, 0xAAAA) and fwd_wb (rd=5, 0xBBBB) valid at capture -> out_in_0=0xAAAA. With rs1=0 and both forwarding ports targeting rd 0 -> out_in_0=0.
- out_ready=0 for 3 cycles, with fwd_wb (rd=6, 0x1234) pulsed in cycle 2 -> in_ready=0 throughout; after the pulse, out_in_1=0x1234 and out_store_data=0x1234; other fields unchanged.
- Back-to-back in_valid with out_ready=1 over 4 instructions -> 4 consecutive out_valid cycles in order, no bubble.
- flush while holding, with in_valid=1 in the same cycle -> out_valid=0 the next cycle and the incoming instruction never appears. Repeat with rst and flush together -> reset values.
- FORWARDING_EN undefined, same stimulus as the second scenario -> out_in_0 equals in_rs1_data.

Source files
------------

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with operand forwarding and ALU operand select
//
// Single-entry valid/ready pipeline register that sits in front of the ALU.
// Register operands are resolved against the MEM and WB results. MEM wins over
// WB, and register 0 always reads as zero. Resolution happens when the
// instruction is captured. It happens again on every stalled cycle, so operands
// that a later stage corrects while the instruction waits do not stay stale.
//
// Build option: FORWARDING_EN. When it is undefined, operands come straight
// from the register file with only x0 zeroing applied. In that build the
// forwarding inputs are ignored and there is no refresh while stalled.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid / in_ready        decode handshake
//   in_pc, in_imm              instruction PC and sign-extended immediate
//   in_rs{1,2}_addr/_data      source indices and register-file read data
//   in_use_pc, in_use_imm      operand select for ALU in_0 / in_1
//   in_operation, in_rd_addr   ALU op code and destination, passed through
//   flush                      kill held and incoming instruction
//   fwd_{mem,wb}_valid/rd/data later-stage results for forwarding
//   out_valid / out_ready      execute handshake
//   out_in_0, out_in_1         ALU operands
//   out_operation, out_rd_addr passed-through op code and destination
//   out_store_data             resolved rs2 value for stores
module ex_operand_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rs1_addr,
    input  logic [4:0]      in_rs2_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_pc,
    input  logic            in_use_imm,
    input  logic [3:0]      in_operation,
    input  logic [4:0]      in_rd_addr,
    input  logic            flush,
    input  logic            fwd_mem_valid,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [XLEN-1:0] fwd_mem_data,
    input  logic            fwd_wb_valid,
    input  logic [4:0]      fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_in_0,
    output logic [XLEN-1:0] out_in_1,
    output logic [3:0]      out_operation,
    output logic [4:0]      out_rd_addr,
    output logic [XLEN-1:0] out_store_data
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [4:0]      rs1_addr_q;
    logic [4:0]      rs2_addr_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [XLEN-1:0] rs2_val_q;
    logic [XLEN-1:0] imm_q;
    logic            use_pc_q;
    logic            use_imm_q;
    logic [3:0]      operation_q;
    logic [4:0]      rd_addr_q;

    logic            load;
    logic            hold;

    // Address and fallback value feeding the resolver: the incoming
    // instruction on a load, the stored one while stalled.
    logic [4:0]      rs1_src_addr;
    logic [4:0]      rs2_src_addr;
    logic [XLEN-1:0] rs1_fallback;
    logic [XLEN-1:0] rs2_fallback;
    logic [XLEN-1:0] rs1_resolved;
    logic [XLEN-1:0] rs2_resolved;

    assign in_ready = !valid_q || out_ready;
    assign load     = in_valid && in_ready && !flush;
    assign hold     = valid_q && !out_ready;

    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      addr,
        input logic [XLEN-1:0] fallback,
        input logic            mem_valid,
        input logic [4:0]      mem_rd,
        input logic [XLEN-1:0] mem_data,
        input logic            wb_valid,
        input logic [4:0]      wb_rd,
        input logic [XLEN-1:0] wb_data
    );
        logic [XLEN-1:0] r;
        if (addr == 5'd0) begin
            r = '0;
        end else if (mem_valid && (mem_rd == addr)) begin
            r = mem_data;
        end else if (wb_valid && (wb_rd == addr)) begin
            r = wb_data;
        end else begin
            r = fallback;
        end
        return r;
    endfunction

    always_comb begin
        rs1_src_addr = load ? in_rs1_addr : rs1_addr_q;
        rs2_src_addr = load ? in_rs2_addr : rs2_addr_q;
        rs1_fallback = load ? in_rs1_data : rs1_val_q;
        rs2_fallback = load ? in_rs2_data : rs2_val_q;
    end

`ifdef FORWARDING_EN
    always_comb begin
        rs1_resolved = resolve(rs1_src_addr, rs1_fallback,
                               fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                               fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
        rs2_resolved = resolve(rs2_src_addr, rs2_fallback,
                               fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                               fwd_wb_valid, fwd_wb_rd, fwd_wb_data);
    end
`else
    // Forwarding disabled: the bypass ports are tied off inside the resolver,
    // so only the x0 zeroing remains.
    always_comb begin
        rs1_resolved = resolve(rs1_src_addr, rs1_fallback,
                               1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        rs2_resolved = resolve(rs2_src_addr, rs2_fallback,
                               1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    end

    logic unused_fwd;
    assign unused_fwd = ^{fwd_mem_valid, fwd_mem_rd, fwd_mem_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            use_pc_q    <= 1'b0;
            use_imm_q   <= 1'b0;
            operation_q <= '0;
            rd_addr_q   <= '0;
        end else if (flush) begin
            // Any transfer accepted in this cycle is dropped along with the held entry.
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q     <= 1'b1;
            pc_q        <= in_pc;
            rs1_addr_q  <= in_rs1_addr;
            rs2_addr_q  <= in_rs2_addr;
            rs1_val_q   <= rs1_resolved;
            rs2_val_q   <= rs2_resolved;
            imm_q       <= in_imm;
            use_pc_q    <= in_use_pc;
            use_imm_q   <= in_use_imm;
            operation_q <= in_operation;
            rd_addr_q   <= in_rd_addr;
        end else if (hold) begin
`ifdef FORWARDING_EN
            // Stalled: pick up results that retired while this instruction waited.
            rs1_val_q <= rs1_resolved;
            rs2_val_q <= rs2_resolved;
`endif
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid      = valid_q;
    assign out_in_0       = use_pc_q  ? pc_q  : rs1_val_q;
    assign out_in_1       = use_imm_q ? imm_q : rs2_val_q;
    assign out_operation  = operation_q;
    assign out_rd_addr    = rd_addr_q;
    assign out_store_data = rs2_val_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage
module tb_ex_operand_stage;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [4:0]  in_rs1_addr = '0;
    logic [4:0]  in_rs2_addr = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic [31:0] in_imm = '0;
    logic        in_use_pc = 1'b0;
    logic        in_use_imm = 1'b0;
    logic [3:0]  in_operation = '0;
    logic [4:0]  in_rd_addr = '0;
    logic        flush = 1'b0;
    logic        fwd_mem_valid = 1'b0;
    logic [4:0]  fwd_mem_rd = '0;
    logic [31:0] fwd_mem_data = '0;
    logic        fwd_wb_valid = 1'b0;
    logic [4:0]  fwd_wb_rd = '0;
    logic [31:0] fwd_wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_in_0;
    logic [31:0] out_in_1;
    logic [3:0]  out_operation;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_store_data;

    ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_pc(in_use_pc), .in_use_imm(in_use_imm),
        .in_operation(in_operation), .in_rd_addr(in_rd_addr),
        .flush(flush),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_in_0(out_in_0), .out_in_1(out_in_1),
        .out_operation(out_operation), .out_rd_addr(out_rd_addr),
        .out_store_data(out_store_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        use_pc, use_imm;
        logic [3:0]  op;
    } vec_t;

    typedef struct {
        logic [31:0] in0, in1, st;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pops = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                                 input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                                 input logic use_pc, input logic use_imm, input logic [3:0] op,
                                 input logic [4:0] rd);
        vec_t v;
        v.pc = pc; v.rs1 = rs1; v.d1 = d1; v.rs2 = rs2; v.d2 = d2; v.imm = imm;
        v.use_pc = use_pc; v.use_imm = use_imm; v.op = op; v.rd = rd;
        return v;
    endfunction

    function automatic exp_t mke(input logic [31:0] in0, input logic [31:0] in1, input logic [31:0] st,
                                 input logic [3:0] op, input logic [4:0] rd);
        exp_t e;
        e.in0 = in0; e.in1 = in1; e.st = st; e.op = op; e.rd = rd;
        return e;
    endfunction

    task automatic set_fwd(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                           input logic wv, input logic [4:0] wrd, input logic [31:0] wd);
        fwd_mem_valid = mv; fwd_mem_rd = mrd; fwd_mem_data = md;
        fwd_wb_valid = wv; fwd_wb_rd = wrd; fwd_wb_data = wd;
    endtask

    // Drives one instruction for exactly one clock edge; the expected response
    // is queued only when the instruction must later reach the execute stage.
    task automatic send(input vec_t v, input exp_t e, input bit push, input logic exp_ready);
        in_pc = v.pc; in_rs1_addr = v.rs1; in_rs1_data = v.d1;
        in_rs2_addr = v.rs2; in_rs2_data = v.d2; in_imm = v.imm;
        in_use_pc = v.use_pc; in_use_imm = v.use_imm;
        in_operation = v.op; in_rd_addr = v.rd;
        in_valid = 1'b1;
        #1;
        chk("in_ready_at_send", {31'd0, in_ready}, {31'd0, exp_ready});
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_in_0"}, out_in_0, 32'd0);
        chk({tag, "_out_in_1"}, out_in_1, 32'd0);
        chk({tag, "_out_operation"}, {28'd0, out_operation}, 32'd0);
        chk({tag, "_out_rd_addr"}, {27'd0, out_rd_addr}, 32'd0);
        chk({tag, "_out_store_data"}, out_store_data, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Monitor: every transfer to the execute stage must match the oldest queued response.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_pops++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got in_0=0x%0h rd=%0d, expected no transfer",
                         out_in_0, out_rd_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("mon_in_0", out_in_0, mon_e.in0);
                chk("mon_in_1", out_in_1, mon_e.in1);
                chk("mon_store_data", out_store_data, mon_e.st);
                chk("mon_operation", {28'd0, out_operation}, {28'd0, mon_e.op});
                chk("mon_rd_addr", {27'd0, out_rd_addr}, {27'd0, mon_e.rd});
            end
        end
    end

    initial begin
        vec_t v;
        exp_t e;
        int   pops_before;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_values("reset");

        // Basic capture and one-cycle latency.
        out_ready = 1'b1;
        send(mkv(32'h100, 5'd5, 32'h10, 5'd6, 32'h20, 32'h7, 1'b0, 1'b0, 4'h1, 5'd3),
             mke(32'h10, 32'h20, 32'h20, 4'h1, 5'd3), 1'b1, 1'b1);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

        // Forwarding at capture: MEM beats WB.
        set_fwd(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
        send(mkv(32'h104, 5'd5, 32'h10, 5'd6, 32'h20, 32'h0, 1'b0, 1'b0, 4'h2, 5'd4),
             mke(FWD ? 32'hAAAA : 32'h10, 32'h20, 32'h20, 4'h2, 5'd4), 1'b1, 1'b1);
        // WB hit on rs2, MEM targets an unrelated register.
        set_fwd(1'b1, 5'd9, 32'h9999, 1'b1, 5'd6, 32'hCCCC);
        send(mkv(32'h108, 5'd5, 32'h10, 5'd6, 32'h20, 32'h0, 1'b0, 1'b0, 4'h3, 5'd5),
             mke(32'h10, FWD ? 32'hCCCC : 32'h20, FWD ? 32'hCCCC : 32'h20, 4'h3, 5'd5), 1'b1, 1'b1);
        // x0 stays zero even when both ports target rd 0.
        set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        send(mkv(32'h10C, 5'd0, 32'h55, 5'd0, 32'h66, 32'h0, 1'b0, 1'b0, 4'h4, 5'd6),
             mke(32'h0, 32'h0, 32'h0, 4'h4, 5'd6), 1'b1, 1'b1);
        // PC and immediate select; store data still carries rs2.
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        send(mkv(32'h200, 5'd7, 32'h77, 5'd8, 32'h88, 32'hFFFF_FFF0, 1'b1, 1'b1, 4'h5, 5'd7),
             mke(32'h200, 32'hFFFF_FFF0, 32'h88, 4'h5, 5'd7), 1'b1, 1'b1);
        @(posedge clk);
        #1;

        // Stall for three cycles with a WB result arriving in the second.
        out_ready = 1'b0;
        send(mkv(32'h300, 5'd5, 32'h10, 5'd6, 32'h20, 32'h44, 1'b0, 1'b0, 4'h2, 5'd7),
             mke(32'h10, FWD ? 32'h1234 : 32'h20, FWD ? 32'h1234 : 32'h20, 4'h2, 5'd7), 1'b1, 1'b1);
        in_rs1_data = 32'hBAD0; in_rs2_data = 32'hBAD1;
        chk("hold1_in_ready", {31'd0, in_ready}, 32'd0);
        chk("hold1_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("hold2_in_ready", {31'd0, in_ready}, 32'd0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h1234);
        @(posedge clk);
        #1;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("hold3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("hold3_out_in_1", out_in_1, FWD ? 32'h1234 : 32'h20);
        chk("hold3_store_data", out_store_data, FWD ? 32'h1234 : 32'h20);
        chk("hold3_out_in_0", out_in_0, 32'h10);
        chk("hold3_operation", {28'd0, out_operation}, 32'h2);
        chk("hold3_rd_addr", {27'd0, out_rd_addr}, 32'd7);
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Four back-to-back instructions, no bubble.
        pops_before = n_pops;
        for (int i = 0; i < 4; i++) begin
            v = mkv(32'h400 + 32'(4 * i), 5'(i + 1), 32'h1000 + 32'(i), 5'(i + 10), 32'h2000 + 32'(i),
                    32'h500 + 32'(i), 1'b0, i[0], 4'(8 + i), 5'(20 + i));
            e = mke(32'h1000 + 32'(i), i[0] ? 32'h500 + 32'(i) : 32'h2000 + 32'(i),
                    32'h2000 + 32'(i), 4'(8 + i), 5'(20 + i));
            send(v, e, 1'b1, 1'b1);
            chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1;
        chk("b2b_transfers", 32'(n_pops - pops_before), 32'd4);
        chk("b2b_drained", {31'd0, out_valid}, 32'd0);

        // Flush while holding, new instruction offered in the same cycle.
        out_ready = 1'b0;
        send(mkv(32'h600, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 1'b0, 1'b0, 4'hE, 5'd30),
             mke(32'h0, 32'h0, 32'h0, 4'h0, 5'd0), 1'b0, 1'b1);
        flush = 1'b1;
        send(mkv(32'h604, 5'd3, 32'h3, 5'd4, 32'h4, 32'h0, 1'b0, 1'b0, 4'hF, 5'd31),
             mke(32'h0, 32'h0, 32'h0, 4'h0, 5'd0), 1'b0, 1'b0);
        flush = 1'b0;
        chk("flush_hold_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("flush_hold_idle", {31'd0, out_valid}, 32'd0);

        // Flush with the stage idle: the accepted transfer is discarded.
        flush = 1'b1;
        send(mkv(32'h608, 5'd3, 32'h3, 5'd4, 32'h4, 32'h0, 1'b0, 1'b0, 4'hD, 5'd29),
             mke(32'h0, 32'h0, 32'h0, 4'h0, 5'd0), 1'b0, 1'b1);
        flush = 1'b0;
        chk("flush_idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Reset together with flush and load while holding.
        out_ready = 1'b0;
        send(mkv(32'h700, 5'd5, 32'h5, 5'd6, 32'h6, 32'h9, 1'b1, 1'b1, 4'hC, 5'd28),
             mke(32'h0, 32'h0, 32'h0, 4'h0, 5'd0), 1'b0, 1'b1);
        rst = 1'b1;
        flush = 1'b1;
        send(mkv(32'h704, 5'd7, 32'h7, 5'd8, 32'h8, 32'hA, 1'b1, 1'b1, 4'hB, 5'd27),
             mke(32'h0, 32'h0, 32'h0, 4'h0, 5'd0), 1'b0, 1'b0);
        rst = 1'b0;
        flush = 1'b0;
        #1;
        chk_reset_values("rst_flush");
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("total_transfers", 32'(n_pops), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
